// File: rtl/pdm_demod_341431502448362067_pkg.sv
// ============================================================================
// pdm_demod_341431502448362067_pkg : shared widths and types for the PDM demodulator
// Rev 1.0 - initial release (build option: PDM_DEMOD_SLIDING_EN)
// ============================================================================
`default_nettype none

package pdm_demod_341431502448362067_pkg;

  localparam int c_DEFAULT_WIDTH = 5;
  localparam int c_DEFAULT_N     = 1 << c_DEFAULT_WIDTH;

  typedef logic [c_DEFAULT_WIDTH-1:0] sample_t;

  typedef enum logic {
    MODE_BLOCK   = 1'b0,
    MODE_SLIDING = 1'b1
  } mode_e;

`ifdef PDM_DEMOD_SLIDING_EN
  localparam mode_e c_MODE = MODE_SLIDING;
`else
  localparam mode_e c_MODE = MODE_BLOCK;
`endif

endpackage

`default_nettype wire

// File: rtl/pdm_demod_341431502448362067_if.sv
// ============================================================================
// pdm_demod_341431502448362067_if : PDM stream in, decoded sample and flags out
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface pdm_demod_341431502448362067_if #(
  parameter int WIDTH = pdm_demod_341431502448362067_pkg::c_DEFAULT_WIDTH
);

  logic             pdm_in;
  logic             restart;
  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             sat;

  modport master (
    output pdm_in,
    output restart,
    input  sample,
    input  sample_valid,
    input  sat
  );

  modport slave (
    input  pdm_in,
    input  restart,
    output sample,
    output sample_valid,
    output sat
  );

endinterface

`default_nettype wire

// File: rtl/pdm_demod_341431502448362067_acc.sv
// ============================================================================
// pdm_demod_acc_341431502448362067 : window position and ones accumulator
// Rev 1.0 - initial release (build option: PDM_DEMOD_SLIDING_EN)
// ============================================================================
`default_nettype none

module pdm_demod_acc_341431502448362067
  import pdm_demod_341431502448362067_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart,
  input  logic             pdm_in,
  output logic             window_end,
  output logic [WIDTH:0]   ones_next
);

  localparam logic [WIDTH-1:0] c_WCNT_LAST = '1;

  logic [WIDTH-1:0] r_wcnt;
  logic [WIDTH:0]   r_ones;

  assign window_end = (r_wcnt == c_WCNT_LAST);

`ifdef PDM_DEMOD_SLIDING_EN
  localparam int c_N = 1 << WIDTH;

  logic [c_N-1:0] r_hist;

  // History is zero during fill, so the subtraction is harmless until it is full.
  assign ones_next = r_ones + (WIDTH+1)'(pdm_in) - (WIDTH+1)'(r_hist[c_N-1]);

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      r_wcnt <= '0;
      r_ones <= '0;
      r_hist <= '0;
    end else begin
      r_hist <= {r_hist[c_N-2:0], pdm_in};
      r_ones <= ones_next;
      if (!window_end) begin
        r_wcnt <= r_wcnt + WIDTH'(1);
      end
    end
  end
`else
  assign ones_next = r_ones + (WIDTH+1)'(pdm_in);

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      r_wcnt <= '0;
      r_ones <= '0;
    end else if (window_end) begin
      r_wcnt <= '0;
      r_ones <= '0;
    end else begin
      r_wcnt <= r_wcnt + WIDTH'(1);
      r_ones <= ones_next;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/pdm_demod_341431502448362067.sv
// ============================================================================
// pdm_demod_341431502448362067 : PDM-to-sample decimator with strobe and sticky clamp flag
// Rev 1.0 - initial release (build option: PDM_DEMOD_SLIDING_EN)
// ============================================================================
`default_nettype none

module pdm_demod_341431502448362067
  import pdm_demod_341431502448362067_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset_n,
  pdm_demod_341431502448362067_if.slave    bus
);

  logic             w_window_end;
  logic [WIDTH:0]   w_ones_next;
  logic             w_clamp;
  logic [WIDTH-1:0] w_sample_next;

  logic [WIDTH-1:0] r_sample;
  logic             r_sample_valid;
  logic             r_sat;

  pdm_demod_acc_341431502448362067 #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart    (bus.restart),
    .pdm_in     (bus.pdm_in),
    .window_end (w_window_end),
    .ones_next  (w_ones_next)
  );

  // ones_next never exceeds N, so its MSB alone marks the one value that must clamp.
  assign w_clamp       = w_ones_next[WIDTH];
  assign w_sample_next = w_clamp ? '1 : w_ones_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sample       <= '0;
      r_sample_valid <= 1'b0;
      r_sat          <= 1'b0;
    end else if (bus.restart) begin
      r_sample_valid <= 1'b0;
      r_sat          <= 1'b0;
    end else begin
      r_sample_valid <= w_window_end;
      if (w_window_end) begin
        r_sample <= w_sample_next;
        if (w_clamp) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_sample_valid;
  assign bus.sat          = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_pdm_demod_341431502448362067.sv
// ============================================================================
// tb_pdm_demod_341431502448362067 : directed self-checking bench for the PDM demodulator
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_demod_341431502448362067;
  import pdm_demod_341431502448362067_pkg::*;

  localparam int c_N = c_DEFAULT_N;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   strobes;
  logic [c_DEFAULT_WIDTH-1:0] mod_acc;
  int   vals [6] = '{10, 10, 10, 31, 1, 0};

  pdm_demod_341431502448362067_if bus ();

  pdm_demod_341431502448362067 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive a bit, take the edge, look 1 time unit later.
  task automatic step(input logic b);
    bus.pdm_in = b;
    @(posedge clk);
    #1;
    if (bus.sample_valid === 1'b1) strobes++;
  endtask

  // First-order modulator: the carry out of the accumulator is the PDM bit.
  task automatic mod_step(input int x);
    logic [c_DEFAULT_WIDTH:0] s;
    logic [c_DEFAULT_WIDTH:0] xv;
    xv = x[c_DEFAULT_WIDTH:0];
    s = {1'b0, mod_acc} + xv;
    mod_acc = s[c_DEFAULT_WIDTH-1:0];
    step(s[c_DEFAULT_WIDTH]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    bus.restart = 1'b0;
    bus.pdm_in  = 1'b0;
    strobes     = 0;
    mod_acc     = '0;
    step(1'b0);
    step(1'b0);
    check_vec("reset_sample", bus.sample, 0);
    check_vec("reset_valid", bus.sample_valid, 0);
    check_vec("reset_sat", bus.sat, 0);
    reset_n = 1'b1;

`ifdef PDM_DEMOD_SLIDING_EN
    begin
      int      miss;
      int      mono;
      sample_t prev;
      strobes = 0;
      for (int i = 0; i < c_N-1; i++) step(1'b0);
      check_vec("fill_no_strobe", strobes, 0);
      step(1'b0);
      check_vec("fill_strobe", bus.sample_valid, 1);
      check_vec("fill_sample", bus.sample, 0);
      miss = 0;
      mono = 0;
      prev = '0;
      mod_acc = '0;
      for (int i = 0; i < c_N; i++) begin
        mod_step(16);
        if (bus.sample_valid !== 1'b1) miss++;
        if (bus.sample < prev) mono++;
        prev = bus.sample;
      end
      check_vec("slide_valid_every_cycle", miss, 0);
      check_vec("slide_monotonic", mono, 0);
      check_vec("slide_final_sample", bus.sample, 16);
      check_vec("slide_sat", bus.sat, 0);
    end
`else
    // Constant zeros: nothing for 31 cycles, then a strobe carrying 0.
    strobes = 0;
    for (int i = 0; i < c_N-1; i++) step(1'b0);
    check_vec("zeros_no_early_strobe", strobes, 0);
    step(1'b0);
    check_vec("zeros_strobe", bus.sample_valid, 1);
    check_vec("zeros_sample", bus.sample, 0);

    // Modulator-driven windows recover the modulator input exactly.
    mod_acc = '0;
    foreach (vals[w]) begin
      strobes = 0;
      for (int i = 0; i < c_N-1; i++) mod_step(vals[w]);
      check_vec($sformatf("mod%0d_mid_strobes", w), strobes, 0);
      mod_step(vals[w]);
      check_vec($sformatf("mod%0d_strobe", w), bus.sample_valid, 1);
      check_vec($sformatf("mod%0d_sample", w), bus.sample, vals[w]);
      check_vec($sformatf("mod%0d_sat", w), bus.sat, 0);
    end

    // All ones: N counted, clamped to N-1, sticky sat until restart.
    for (int i = 0; i < c_N; i++) step(1'b1);
    check_vec("ones_strobe", bus.sample_valid, 1);
    check_vec("ones_sample", bus.sample, c_N-1);
    check_vec("ones_sat", bus.sat, 1);
    step(1'b0);
    check_vec("strobe_one_cycle", bus.sample_valid, 0);
    for (int i = 0; i < 4; i++) step(1'b0);
    check_vec("sat_sticky", bus.sat, 1);
    bus.restart = 1'b1;
    step(1'b0);
    bus.restart = 1'b0;
    check_vec("restart_sat_clear", bus.sat, 0);
    check_vec("restart_valid", bus.sample_valid, 0);
    check_vec("restart_sample_hold", bus.sample, c_N-1);

    // Restart at wcnt=20 suppresses the old window end.
    for (int i = 0; i < c_N; i++) step(1'b0);
    check_vec("pre_restart_sample", bus.sample, 0);
    for (int i = 0; i < 20; i++) step(1'b1);
    bus.restart = 1'b1;
    step(1'b1);
    bus.restart = 1'b0;
    check_vec("restart20_valid", bus.sample_valid, 0);
    strobes = 0;
    for (int i = 0; i < c_N-1; i++) step(1'b1);
    check_vec("restart20_no_old_strobe", strobes, 0);
    check_vec("restart20_sample_hold", bus.sample, 0);
    step(1'b1);
    check_vec("restart20_strobe", bus.sample_valid, 1);
    check_vec("restart20_sample", bus.sample, c_N-1);
    check_vec("restart20_sat", bus.sat, 1);

    // Reset mid-window at wcnt=15.
    for (int i = 0; i < 15; i++) step(1'b0);
    reset_n = 1'b0;
    step(1'b0);
    reset_n = 1'b1;
    check_vec("midreset_sample", bus.sample, 0);
    check_vec("midreset_valid", bus.sample_valid, 0);
    check_vec("midreset_sat", bus.sat, 0);
    strobes = 0;
    for (int i = 0; i < c_N-1; i++) step(1'b1);
    check_vec("midreset_no_early_strobe", strobes, 0);
    step(1'b1);
    check_vec("midreset_strobe", bus.sample_valid, 1);
    check_vec("midreset_sample_after", bus.sample, c_N-1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pdm_demod_341431502448362067.md
# pdm_demod_341431502448362067

Receive-side counterpart of the team's first-order PDM modulator. It converts a 1-bit pulse-density stream back into a WIDTH-bit sample by counting ones over a 2^WIDTH-cycle window, and flags each new sample with a one-cycle strobe. With the default WIDTH of 5 and a 32-cycle window, it exactly recovers any constant 5-bit value driven into the modulator on the same clock. It sits on a TinyTapeout tile, pins mapped by the tile wrapper.

## Interface
Parameters:
- WIDTH, 5, sample width; window length N = 2^WIDTH cycles

Ports:
- clk  input  1  the single clock; everything is posedge clk
- reset_n  input  1  synchronous, active-low reset
- pdm_in  input  1  PDM bit stream, sampled every clk rising edge
- restart  input  1  synchronous; aborts the current window and starts a new one
- sample  output  WIDTH  last decoded value, held between updates
- sample_valid  output  1  one-cycle strobe: sample updated this cycle
- sat  output  1  sticky: a window counted N ones and was clamped

## Operation
Internal state:
- wcnt: WIDTH bits, position in the window (0..N-1)
- ones: WIDTH+1 bits, ones counted so far in the window

Reset (reset_n=0 at a clk edge):
- wcnt=0, ones=0, sample=0, sample_valid=0, sat=0
- Applies immediately mid-window; a partial window is discarded with no strobe

Each cycle with reset_n=1 and restart=0:
- ones_next = ones + pdm_in
- When wcnt < N-1: ones <= ones_next, wcnt <= wcnt+1
- When wcnt = N-1 (window end):
  - sample <= min(ones_next, N-1); the value N clamps to N-1 and sets sat
  - sample_valid <= 1, ones <= 0, wcnt <= 0 (wrap)
- All other cycles: sample_valid <= 0

restart=1 (with reset_n=1):
- wcnt <= 0, ones <= 0, sat <= 0, sample_valid <= 0
- sample holds its value
- Takes priority over window end in the same cycle: no strobe, and that window's bit is dropped

Width rules:
- ones never exceeds N, so WIDTH+1 bits suffice
- The clamp is the only non-modular arithmetic

## Timing
- Window = N consecutive pdm_in samples, taken at edges k..k+N-1 after reset or restart deassertion
- sample and sample_valid change at edge k+N-1, visible during the following cycle (latency is 1 clk after the last bit of the window)
- Block mode: sample_valid pulses exactly once every N cycles, never on consecutive cycles
- The sat flag asserts in the same cycle as the clamped sample's strobe and stays set until reset or restart

## Configuration
Macro: PDM_DEMOD_SLIDING_EN.

Without the macro (default), the block uses block decimation as described above.

With the macro defined, the block uses a sliding boxcar filter:
- Adds an N-bit history shift register
- Running sum: ones <= ones + pdm_in - oldest bit
- wcnt acts as a fill counter; once N bits have been taken, it stops at N-1
- After the fill completes, sample updates every cycle (same clamp) and sample_valid stays high
- The first strobe comes at the same edge as in block mode
- restart and reset also clear the history register

## Structure
- Shared package: WIDTH default, derived N = 2^WIDTH, and the sample typedef logic [WIDTH-1:0]
- One sub-module, pdm_demod_acc_341431502448362067, holds ones, wcnt and the history register (when compiled in) and outputs window_end and ones_next
- The top module holds sample, sat, the strobe and the restart priority

## Test plan
- Modulator at the same clock, input 10, after its reset: every 32-cycle window gives sample=10 with one strobe per 32 cycles; sat=0
- pdm_in held at 1 for 32 cycles: sample=31, sat=1 in the strobe cycle; sat stays at 1 until restart, then reads 0
- pdm_in held at 0: sample=0 at each strobe; no strobe during the first 31 cycles after reset
- restart pulsed at wcnt=20, then 32 ones: no strobe at the old window end; next strobe 32 cycles after restart with sample=31; sample holds the previous value until then
- reset_n low at wcnt=15 for one cycle: all outputs read 0 the next cycle; the first strobe arrives 32 cycles after release
- With PDM_DEMOD_SLIDING_EN, modulator input stepped from 0 to 16 after fill: sample_valid stays high every cycle; sample rises monotonically and reaches 16 within 32 cycles
